// File: rtl/uc_atualiza_tiros_pkg.sv
// Shared definitions for the shot-table control units: FSM state codes,
// direction encoding with its unit-step table, and the shot record layout.
package uc_atualiza_tiros_pkg;

  // Default sizing, shared with the shot-registration UC.
  localparam int unsigned N_TIROS_DEF = 8;
  localparam int unsigned COORD_W_DEF = 4;
  localparam int unsigned REG_W_DEF   = 4 + 2 * COORD_W_DEF;

  // Record layout {loaded, dir, x, y}, MSB first, for the default coordinate width.
  localparam int unsigned LOADED_BIT = REG_W_DEF - 1;
  localparam int unsigned DIR_MSB    = REG_W_DEF - 2;
  localparam int unsigned DIR_LSB    = 2 * COORD_W_DEF;
  localparam int unsigned X_MSB      = 2 * COORD_W_DEF - 1;
  localparam int unsigned X_LSB      = COORD_W_DEF;
  localparam int unsigned Y_MSB      = COORD_W_DEF - 1;
  localparam int unsigned Y_LSB      = 0;

  // State codes are visible on db_estado, so the values are fixed.
  typedef enum logic [3:0] {
    StInicial        = 4'd0,
    StEspera         = 4'd1,
    StZeraContador   = 4'd2,
    StLeMemoria      = 4'd3,
    StVerificaLoaded = 4'd4,
    StMove           = 4'd5,
    StEscreve        = 4'd6,
    StEmite          = 4'd7,
    StIncrementa     = 4'd8,
    StFim            = 4'd9
  } estado_e;

  typedef enum logic [2:0] {
    DirN  = 3'd0,
    DirNE = 3'd1,
    DirE  = 3'd2,
    DirSE = 3'd3,
    DirS  = 3'd4,
    DirSW = 3'd5,
    DirW  = 3'd6,
    DirNW = 3'd7
  } dir_e;

  // Unit step along x for a direction code (screen y grows downwards).
  function automatic logic signed [1:0] dir_dx(input logic [2:0] dir);
    logic signed [1:0] dx;
    dx = 2'sd0;
    unique case (dir)
      DirN, DirS:         dx = 2'sd0;
      DirNE, DirE, DirSE: dx = 2'sd1;
      DirSW, DirW, DirNW: dx = -2'sd1;
      default:            dx = 2'sd0;
    endcase
    return dx;
  endfunction

  // Unit step along y for a direction code.
  function automatic logic signed [1:0] dir_dy(input logic [2:0] dir);
    logic signed [1:0] dy;
    dy = 2'sd0;
    unique case (dir)
      DirE, DirW:         dy = 2'sd0;
      DirSE, DirS, DirSW: dy = 2'sd1;
      DirN, DirNE, DirNW: dy = -2'sd1;
      default:            dy = 2'sd0;
    endcase
    return dy;
  endfunction

endpackage

// File: rtl/calc_movimento_tiro.sv
// Combinational one-step shot mover: applies the direction's unit step and
// flags results that leave the screen (no wrap-around).
module calc_movimento_tiro
  import uc_atualiza_tiros_pkg::*;
#(
  parameter int unsigned COORD_W = COORD_W_DEF
) (
  input  logic [2:0]         dir_i,
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  output logic [COORD_W-1:0] nx_o,
  output logic [COORD_W-1:0] ny_o,
  output logic               fora_tela_o
);

  logic signed [1:0]       dx2, dy2;
  logic signed [COORD_W:0] dx, dy, sx, sy;

  // One extra bit holds both underflow (-1) and overflow (2^COORD_W) in its MSB.
  always_comb begin
    dx2         = dir_dx(dir_i);
    dy2         = dir_dy(dir_i);
    dx          = {{(COORD_W - 1){dx2[1]}}, dx2};
    dy          = {{(COORD_W - 1){dy2[1]}}, dy2};
    sx          = $signed({1'b0, x_i}) + dx;
    sy          = $signed({1'b0, y_i}) + dy;
    nx_o        = sx[COORD_W-1:0];
    ny_o        = sy[COORD_W-1:0];
    fora_tela_o = sx[COORD_W] | sy[COORD_W];
  end

endmodule

// File: rtl/uc_atualiza_tiros.sv
// Shot-update control unit: once per iniciar, walks every shot slot, moves
// loaded shots one step, writes them back (cleared if off-screen) and hands
// surviving shots to the frame generator over valid/ready.
module uc_atualiza_tiros
  import uc_atualiza_tiros_pkg::*;
#(
  parameter int unsigned N_TIROS = N_TIROS_DEF,
  parameter int unsigned COORD_W = COORD_W_DEF,
  parameter int unsigned REG_W   = 4 + 2 * COORD_W,
  parameter int unsigned AW      = $clog2(N_TIROS)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               iniciar,
  output logic [AW-1:0]      mem_addr,
  input  logic [REG_W-1:0]   mem_rd_data,
  output logic               mem_we,
  output logic [REG_W-1:0]   mem_wr_data,
  output logic               tiro_valid,
  input  logic               tiro_ready,
  output logic [COORD_W-1:0] tiro_x,
  output logic [COORD_W-1:0] tiro_y,
  output logic               pronto,
  output logic [3:0]         db_estado
);

  // Record layout for this instance's coordinate width.
  localparam int unsigned LoadedBit = REG_W - 1;
  localparam int unsigned DirMsb    = REG_W - 2;
  localparam int unsigned DirLsb    = 2 * COORD_W;
  localparam int unsigned XMsb      = 2 * COORD_W - 1;
  localparam int unsigned XLsb      = COORD_W;
  localparam int unsigned YMsb      = COORD_W - 1;
  localparam logic [AW-1:0] LastSlot = AW'(N_TIROS - 1);

  estado_e state_q, state_d;

  logic [AW-1:0]      cnt_q, cnt_d;
  logic [2:0]         dir_q, dir_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [COORD_W-1:0] nx_q, nx_d, ny_q, ny_d;
  logic               fora_q, fora_d;

  logic [COORD_W-1:0] calc_nx, calc_ny;
  logic               calc_fora;

  calc_movimento_tiro #(
    .COORD_W (COORD_W)
  ) u_calc (
    .dir_i       (dir_q),
    .x_i         (x_q),
    .y_i         (y_q),
    .nx_o        (calc_nx),
    .ny_o        (calc_ny),
    .fora_tela_o (calc_fora)
  );

  // State register; reset wins over any in-flight pass.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StInicial;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StInicial:        state_d = StEspera;
      StEspera:         if (iniciar) state_d = StZeraContador;
      StZeraContador:   state_d = StLeMemoria;
      StLeMemoria:      state_d = StVerificaLoaded;
      StVerificaLoaded: state_d = mem_rd_data[LoadedBit] ? StMove : StIncrementa;
      StMove:           state_d = StEscreve;
      StEscreve:        state_d = fora_q ? StIncrementa : StEmite;
      StEmite:          if (tiro_ready) state_d = StIncrementa;
      StIncrementa:     state_d = (cnt_q == LastSlot) ? StFim : StLeMemoria;
      StFim:            state_d = StEspera;
      default:          state_d = StInicial;
    endcase
  end

  // Datapath registers: slot counter, latched record and moved position.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q  <= '0;
      dir_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
      nx_q   <= '0;
      ny_q   <= '0;
      fora_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      x_q    <= x_d;
      y_q    <= y_d;
      nx_q   <= nx_d;
      ny_q   <= ny_d;
      fora_q <= fora_d;
    end
  end

  // Datapath next-state: RAM data is captured in verifica, movement in move.
  always_comb begin
    cnt_d  = cnt_q;
    dir_d  = dir_q;
    x_d    = x_q;
    y_d    = y_q;
    nx_d   = nx_q;
    ny_d   = ny_q;
    fora_d = fora_q;
    unique case (state_q)
      StZeraContador: cnt_d = '0;
      StVerificaLoaded: begin
        dir_d = mem_rd_data[DirMsb:DirLsb];
        x_d   = mem_rd_data[XMsb:XLsb];
        y_d   = mem_rd_data[YMsb:0];
      end
      StMove: begin
        nx_d   = calc_nx;
        ny_d   = calc_ny;
        fora_d = calc_fora;
      end
      StIncrementa: if (cnt_q != LastSlot) cnt_d = cnt_q + AW'(1);
      default: ;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    mem_addr    = '0;
    mem_we      = 1'b0;
    mem_wr_data = '0;
    tiro_valid  = 1'b0;
    tiro_x      = '0;
    tiro_y      = '0;
    pronto      = 1'b0;
    db_estado   = state_q;
    if (state_q != StInicial && state_q != StEspera) mem_addr = cnt_q;
    unique case (state_q)
      StEscreve: begin
        mem_we = 1'b1;
        // Off-screen shots are written back as an empty slot.
        if (!fora_q) mem_wr_data = {1'b1, dir_q, nx_q, ny_q};
      end
      StEmite: begin
        tiro_valid = 1'b1;
        tiro_x     = nx_q;
        tiro_y     = ny_q;
      end
      StFim:   pronto = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uc_atualiza_tiros.sv
// Directed bench for uc_atualiza_tiros with a synchronous-read shot RAM model.
module tb_uc_atualiza_tiros;

  localparam int unsigned N  = 8;
  localparam int unsigned CW = 4;
  localparam int unsigned RW = 12;
  localparam int unsigned AW = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          iniciar;
  logic [AW-1:0] mem_addr;
  logic [RW-1:0] mem_rd_data;
  logic          mem_we;
  logic [RW-1:0] mem_wr_data;
  logic          tiro_valid;
  logic          tiro_ready;
  logic [CW-1:0] tiro_x;
  logic [CW-1:0] tiro_y;
  logic          pronto;
  logic [3:0]    db_estado;

  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [RW-1:0] load_data = '0;
  logic [RW-1:0] ram [N];

  int checks = 0;
  int errors = 0;

  int            we_cnt = 0;
  int            valid_cyc = 0;
  int            hs_cnt = 0;
  int            pronto_cnt = 0;
  logic [AW-1:0] last_addr = '0;
  logic [RW-1:0] last_data = '0;
  logic [CW-1:0] hs_x = '0;
  logic [CW-1:0] hs_y = '0;

  uc_atualiza_tiros dut (
    .clock       (clock),
    .reset       (reset),
    .iniciar     (iniciar),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .mem_we      (mem_we),
    .mem_wr_data (mem_wr_data),
    .tiro_valid  (tiro_valid),
    .tiro_ready  (tiro_ready),
    .tiro_x      (tiro_x),
    .tiro_y      (tiro_y),
    .pronto      (pronto),
    .db_estado   (db_estado)
  );

  always #5 clock = ~clock;

  // RAM: synchronous read, bench-side loads take priority over DUT writes.
  always @(posedge clock) begin
    if (load_en) ram[load_addr] <= load_data;
    else if (mem_we) ram[mem_addr] <= mem_wr_data;
    mem_rd_data <= ram[mem_addr];
  end

  // Event monitor sampling DUT outputs just before each edge.
  always @(posedge clock) begin
    if (mem_we) begin
      we_cnt++;
      last_addr = mem_addr;
      last_data = mem_wr_data;
    end
    if (tiro_valid) valid_cyc++;
    if (tiro_valid && tiro_ready) begin
      hs_cnt++;
      hs_x = tiro_x;
      hs_y = tiro_y;
    end
    if (pronto) pronto_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int addr, input logic [RW-1:0] data);
    load_en   = 1'b1;
    load_addr = AW'(addr);
    load_data = data;
    step();
    load_en = 1'b0;
  endtask

  task automatic clear_ram();
    for (int i = 0; i < N; i++) load(i, '0);
  endtask

  task automatic pulse_iniciar();
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
  endtask

  task automatic wait_state(input logic [3:0] s, input string tag);
    for (int i = 0; i < 300; i++) begin
      if (db_estado == s) break;
      step();
    end
    check(tag, 32'(db_estado), 32'(s));
  endtask

  task automatic wait_pronto(input string tag);
    for (int i = 0; i < 300; i++) begin
      if (pronto) break;
      step();
    end
    check(tag, 32'(pronto), 32'd1);
  endtask

  initial begin
    int w0, v0, h0, p0, n;
    reset      = 1'b1;
    iniciar    = 1'b0;
    tiro_ready = 1'b0;
    clear_ram();
    step();

    // Reset state
    check("rst_estado", 32'(db_estado), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_valid", 32'(tiro_valid), 32'd0);
    check("rst_pronto", 32'(pronto), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wr_data", 32'(mem_wr_data), 32'd0);
    reset = 1'b0;
    step();
    check("espera_after_rst", 32'(db_estado), 32'd1);

    // 1: empty table -> pronto 25 edges after the sampling edge
    w0 = we_cnt; v0 = valid_cyc;
    pulse_iniciar();
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (pronto) begin
        n = k;
        break;
      end
    end
    check("t1_pronto_edge", 32'(n), 32'd25);
    step();
    check("t1_pronto_pulse", 32'(pronto), 32'd0);
    check("t1_back_espera", 32'(db_estado), 32'd1);
    check("t1_no_we", 32'(we_cnt - w0), 32'd0);
    check("t1_no_valid", 32'(valid_cyc - v0), 32'd0);

    // 2: slot 3 {1,E,5,7}, ready held low 4 cycles
    load(3, 12'hA57);
    w0 = we_cnt; h0 = hs_cnt;
    pulse_iniciar();
    wait_state(4'd7, "t2_reach_emite");
    for (int i = 0; i < 4; i++) begin
      check("t2_valid_hold", 32'(tiro_valid), 32'd1);
      check("t2_x_hold", 32'(tiro_x), 32'd6);
      check("t2_y_hold", 32'(tiro_y), 32'd7);
      step();
    end
    tiro_ready = 1'b1;
    check("t2_valid_hs", 32'(tiro_valid), 32'd1);
    check("t2_x_hs", 32'(tiro_x), 32'd6);
    check("t2_y_hs", 32'(tiro_y), 32'd7);
    step();
    tiro_ready = 1'b0;
    check("t2_valid_drop", 32'(tiro_valid), 32'd0);
    check("t2_incrementa", 32'(db_estado), 32'd8);
    wait_pronto("t2_pronto");
    step();
    check("t2_we_count", 32'(we_cnt - w0), 32'd1);
    check("t2_we_addr", 32'(last_addr), 32'd3);
    check("t2_we_data", 32'(last_data), 32'hA67);
    check("t2_ram3", 32'(ram[3]), 32'hA67);
    check("t2_hs_count", 32'(hs_cnt - h0), 32'd1);

    // 3: slot 0 {1,W,0,4} leaves through x=-1
    clear_ram();
    load(0, 12'hE04);
    w0 = we_cnt; v0 = valid_cyc;
    pulse_iniciar();
    wait_pronto("t3_pronto");
    step();
    check("t3_we_count", 32'(we_cnt - w0), 32'd1);
    check("t3_we_addr", 32'(last_addr), 32'd0);
    check("t3_we_data", 32'(last_data), 32'd0);
    check("t3_ram0", 32'(ram[0]), 32'd0);
    check("t3_no_valid", 32'(valid_cyc - v0), 32'd0);

    // 4: slot 5 {1,NE,15,3} leaves via x=16; slot 6 {1,SE,14,14} -> (15,15)
    clear_ram();
    load(5, 12'h9F3);
    load(6, 12'hBEE);
    w0 = we_cnt; h0 = hs_cnt;
    tiro_ready = 1'b1;
    pulse_iniciar();
    wait_pronto("t4_pronto");
    step();
    tiro_ready = 1'b0;
    check("t4_we_count", 32'(we_cnt - w0), 32'd2);
    check("t4_ram5", 32'(ram[5]), 32'd0);
    check("t4_ram6", 32'(ram[6]), 32'hBFF);
    check("t4_last_addr", 32'(last_addr), 32'd6);
    check("t4_hs_count", 32'(hs_cnt - h0), 32'd1);
    check("t4_hs_x", 32'(hs_x), 32'd15);
    check("t4_hs_y", 32'(hs_y), 32'd15);

    // 5: reset while in emite, then a fresh full pass
    clear_ram();
    load(2, 12'hC82);
    pulse_iniciar();
    wait_state(4'd7, "t5_reach_emite");
    check("t5_emite_x", 32'(tiro_x), 32'd8);
    check("t5_emite_y", 32'(tiro_y), 32'd3);
    w0 = we_cnt;
    reset = 1'b1;
    step();
    check("t5_rst_valid", 32'(tiro_valid), 32'd0);
    check("t5_rst_estado", 32'(db_estado), 32'd0);
    check("t5_rst_addr", 32'(mem_addr), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("t5_idle_espera", 32'(db_estado), 32'd1);
    check("t5_no_we_after_rst", 32'(we_cnt - w0), 32'd0);
    check("t5_ram2_first", 32'(ram[2]), 32'hC83);
    tiro_ready = 1'b1;
    pulse_iniciar();
    wait_pronto("t5_pronto");
    step();
    tiro_ready = 1'b0;
    check("t5_ram2_second", 32'(ram[2]), 32'hC84);

    // 6: iniciar pulses during a pass are ignored
    clear_ram();
    p0 = pronto_cnt;
    pulse_iniciar();
    for (int k = 0; k < 20; k++) begin
      iniciar = ((k % 3) == 1);
      step();
    end
    iniciar = 1'b0;
    wait_pronto("t6_pronto");
    for (int i = 0; i < 10; i++) step();
    check("t6_one_pronto", 32'(pronto_cnt - p0), 32'd1);
    check("t6_espera", 32'(db_estado), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
